// File: rtl/sap1_pkg.sv
// sap1_pkg: shared constants for the SAP-1 control unit.
//   - 4-bit opcodes recognised by the decoder
//   - bit positions inside the 12-bit control word
//   - one-hot ring-counter states T1..T6
package sap1_pkg;

  localparam int CON_W = 12;
  localparam int T_W   = 6;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int CON_CP = 11;
  localparam int CON_EP = 10;
  localparam int CON_LM = 9;
  localparam int CON_CE = 8;
  localparam int CON_LI = 7;
  localparam int CON_EI = 6;
  localparam int CON_LA = 5;
  localparam int CON_EA = 4;
  localparam int CON_SU = 3;
  localparam int CON_EU = 2;
  localparam int CON_LB = 1;
  localparam int CON_LO = 0;

  typedef enum logic [T_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: six-state one-hot timing ring for the SAP-1 controller.
// Ports:
//   clk     - system clock, rising edge
//   clr     - synchronous active-high reset, forces T1
//   hold    - freeze the ring in its current state
//   t_state - one-hot timing state (bit0 = T1 ... bit5 = T6)
//
// state | meaning
// T1    | address state: PC onto bus, load MAR
// T2    | increment state: PC + 1
// T3    | memory state: RAM word into IR
// T4    | execute step 1
// T5    | execute step 2
// T6    | execute step 3, then back to T1
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           hold,
  output logic [T_W-1:0] t_state
);

  t_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (clr) state_q <= T1;
    else     state_q <= state_d;
  end

  // Any non-one-hot value falls back to T1, so the ring self-recovers.
  always_comb begin
    state_d = T1;
    case (state_q)
      T1:      state_d = hold ? T1 : T2;
      T2:      state_d = hold ? T2 : T3;
      T3:      state_d = hold ? T3 : T4;
      T4:      state_d = hold ? T4 : T5;
      T5:      state_d = hold ? T5 : T6;
      T6:      state_d = hold ? T6 : T1;
      default: state_d = T1;
    endcase
  end

  assign t_state = state_q;

endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 control unit (ring counter + halt flag + decode).
// Ports:
//   clk     - system clock, rising edge
//   clr     - synchronous active-high reset
//   opcode  - upper nibble of the instruction register
//   con     - control word {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
//   t_state - one-hot timing state (bit0 = T1 ... bit5 = T6)
//   hlt     - registered halt flag
module sap1_controller
  import sap1_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [3:0]       opcode,
  output logic [CON_W-1:0] con,
  output logic [T_W-1:0]   t_state,
  output logic             hlt
);

  logic hlt_q, hlt_d;
  logic halt_now;
  logic ring_hold;

  // HLT in T4 must stop the ring on the same edge that sets the flag,
  // otherwise the counter would already have stepped to T5.
  assign halt_now  = (t_state == T4) && (opcode == OP_HLT);
  assign ring_hold = hlt_q | halt_now;
  assign hlt_d     = hlt_q | halt_now;

  sap1_ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .hold    (ring_hold),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (clr) hlt_q <= 1'b0;
    else     hlt_q <= hlt_d;
  end

  assign hlt = hlt_q;

  always_comb begin
    con = '0;
    if (!hlt_q) begin
      case (t_state)
        T1: begin
          con[CON_EP] = 1'b1;
          con[CON_LM] = 1'b1;
        end
        T2: con[CON_CP] = 1'b1;
        T3: begin
          con[CON_CE] = 1'b1;
          con[CON_LI] = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              con[CON_EI] = 1'b1;
              con[CON_LM] = 1'b1;
            end
            OP_OUT: begin
              con[CON_EA] = 1'b1;
              con[CON_LO] = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              con[CON_CE] = 1'b1;
              con[CON_LA] = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              con[CON_CE] = 1'b1;
              con[CON_LB] = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              con[CON_EU] = 1'b1;
              con[CON_LA] = 1'b1;
            end
            OP_SUB: begin
              con[CON_SU] = 1'b1;
              con[CON_EU] = 1'b1;
              con[CON_LA] = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sap1_controller.md
SAP1_CONTROLLER -- requirements
Module: sap1_controller

Interface
REQ-001 Parameters: none; all opcodes, control-bit positions and T-state codes are fixed constants.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 clr  input  1  synchronous, active-high reset.
REQ-004 opcode  input  4  upper nibble of the instruction register; stable from end of T3 onward.
REQ-005 con  output  12  control word, all bits active-high: [11]Cp [10]Ep [9]Lm [8]CE [7]Li [6]Ei [5]La [4]Ea [3]Su [2]Eu [1]Lb [0]Lo.
REQ-006 t_state  output  6  one-hot ring-counter state: bit0=T1 ... bit5=T6.
REQ-007 hlt  output  1  registered halt flag, high once HLT has executed.

Function
REQ-008 Ring counter SHALL advance T1->T2->T3->T4->T5->T6->T1, one step per clk edge, while clr=0 and hlt=0.
REQ-009 t_state SHALL be one-hot at all times; no all-zero or multi-hot value is reachable.
REQ-010 con SHALL be combinational from t_state, opcode and hlt; no extra latency beyond t_state.
REQ-011 Fetch, for any opcode: T1 con=0x600 (Ep,Lm); T2 con=0x800 (Cp); T3 con=0x180 (CE,Li).
REQ-012 LDA (0000): T4 0x240 (Ei,Lm); T5 0x120 (CE,La); T6 0x000.
REQ-013 ADD (0001): T4 0x240; T5 0x102 (CE,Lb); T6 0x024 (Eu,La).
REQ-014 SUB (0010): T4 0x240; T5 0x102; T6 0x02C (Su,Eu,La).
REQ-015 OUT (1110): T4 0x011 (Ea,Lo); T5 0x000; T6 0x000.
REQ-016 HLT (1111): T4 con=0x000; on the edge ending T4, hlt SHALL set to 1.
REQ-017 Any other opcode SHALL execute as NOP: con=0x000 in T4-T6; counter keeps cycling.
REQ-018 While hlt=1: t_state SHALL hold T4 (6'b001000), con SHALL be 0x000, hlt SHALL stay 1 until clr.
REQ-019 At most one bus driver (Ep, CE, Ei, Ea, Eu) SHALL be active in any T-state.
REQ-020 opcode changes during T1-T3 SHALL not affect con (fetch words are opcode-independent).

Reset
REQ-021 clr=1 at a rising edge SHALL force t_state=T1 (6'b000001) and hlt=0 on that edge; con then equals 0x600.
REQ-022 clr SHALL take priority over advancement and over halt, in any state including mid-instruction T5/T6.
REQ-023 While clr is held high, t_state SHALL remain T1; first advance is on the first edge with clr=0.
REQ-024 Before the first clr edge, outputs are undefined; the bench SHALL apply clr before checking.

Structure
REQ-025 Package sap1_pkg SHALL hold opcode constants (LDA, ADD, SUB, OUT, HLT), con bit-index constants and T1-T6 one-hot constants; shared with datapath and top.
REQ-026 One sub-module sap1_ring_counter (clk, clr, hold -> t_state) SHALL implement REQ-008/009/021; sap1_controller holds halt flag and decode.
REQ-027 Decode SHALL be a single case on t_state with nested opcode case; no latches.

Verification
REQ-028 Reset: clr high 2 edges, release -> t_state 000001, con 0x600, hlt 0; then 000010/0x800, 000100/0x180.
REQ-029 LDA then ADD then SUB back-to-back -> T4..T6 con sequences 0x240,0x120,0x000 / 0x240,0x102,0x024 / 0x240,0x102,0x02C.
REQ-030 OUT (1110) -> T4 con 0x011, T5/T6 0x000, then T1 0x600.
REQ-031 HLT (1111) -> after T4 edge hlt=1, t_state frozen 001000, con 0x000 for 20 cycles; clr pulse -> T1, hlt=0.
REQ-032 clr asserted during ADD T5 -> next edge t_state 000001, con 0x600; no T6 0x024 issued.
REQ-033 Opcode 0101 (NOP) -> con 0x000 in T4-T6; opcode toggled during T1-T3 leaves fetch words unchanged; one-hot assertion checked every cycle.
